// File: rtl/seq_1011_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : seq_1011_frame_tx
// Purpose  : Serial frame transmitter for the 1011 Mealy detector link.
//            A word accepted through a valid/ready handshake is sent on x,
//            MSB-first, as: PREAMBLE, then the DATA_W payload bits, then GAP
//            idle zeros. Afterwards the block returns to IDLE for one cycle
//            before it can accept again.
// Ports    : clk         in   rising-edge clock
//            reset       in   asynchronous, active-low reset
//            data_in     in   payload word, sampled only on accept
//            data_valid  in   payload offered
//            in_ready    out  high only in IDLE (accept = data_valid & in_ready)
//            x           out  registered serial output, 0 when not sending
//            tx_busy     out  complement of in_ready
//            frame_done  out  1-cycle pulse while the last data bit is on x
// Revision : 1.0  initial release
// ============================================================================
module seq_1011_frame_tx #(
  parameter int               DATA_W   = 8,
  parameter int               PRE_W    = 4,
  parameter logic [PRE_W-1:0] PREAMBLE = 4'b1011,
  parameter int               GAP      = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              in_ready,
  output logic              x,
  output logic              tx_busy,
  output logic              frame_done
);

  localparam int c_MAX_PD = (PRE_W > DATA_W) ? PRE_W : DATA_W;
  localparam int c_MAX_W0 = (c_MAX_PD > GAP) ? c_MAX_PD : GAP;
  localparam int c_MAX_W  = (c_MAX_W0 > 1) ? c_MAX_W0 : 1;
  localparam int c_CNT_W  = $clog2(c_MAX_W) + 1;
  localparam int c_SR_W   = PRE_W + DATA_W;

  localparam logic [c_CNT_W-1:0] c_PRE_LAST  = c_CNT_W'(PRE_W - 1);
  localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(DATA_W - 1);
  localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'((GAP > 0) ? (GAP - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_DATA = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [c_CNT_W-1:0]  w_cnt_nxt;
  // Preamble and payload share one shift register; its MSB is x. Zeros shift
  // in from the bottom, so once all PRE_W+DATA_W bits are out, x idles at 0.
  logic [c_SR_W-1:0]   r_sr;
  logic [c_SR_W-1:0]   w_sr_nxt;
  logic                r_in_ready;
  logic                r_tx_busy;
  logic                r_frame_done;
  logic                w_accept;

  always_comb begin
    w_accept    = data_valid & r_in_ready;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + c_CNT_W'(1);
    w_sr_nxt    = {r_sr[c_SR_W-2:0], 1'b0};

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_sr_nxt  = '0;
        if (w_accept) begin
          w_state_nxt = S_PRE;
          w_sr_nxt    = {PREAMBLE, data_in};
        end
      end
      S_PRE: begin
        if (r_cnt == c_PRE_LAST) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = '0;
        end
      end
      S_DATA: begin
        if (r_cnt == c_DATA_LAST) begin
          w_state_nxt = (GAP == 0) ? S_IDLE : S_GAP;
          w_cnt_nxt   = '0;
        end
      end
      S_GAP: begin
        if (r_cnt == c_GAP_LAST) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_sr_nxt    = '0;
      end
    endcase
  end

  // Status outputs are registered from the next-state decode so they line up
  // with the state the block is in during the following cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_sr         <= '0;
      r_in_ready   <= 1'b1;
      r_tx_busy    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_sr         <= w_sr_nxt;
      r_in_ready   <= (w_state_nxt == S_IDLE);
      r_tx_busy    <= (w_state_nxt != S_IDLE);
      r_frame_done <= (w_state_nxt == S_DATA) && (w_cnt_nxt == c_DATA_LAST);
    end
  end

  assign x          = r_sr[c_SR_W-1];
  assign in_ready   = r_in_ready;
  assign tx_busy    = r_tx_busy;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire
